bpu_upd_sched: RTL and testbench

Branch-predictor update scheduler sitting between the two execution-lane branch resolvers and the single BPU flush/update port. It accepts up to two resolved-branch updates per cycle and buffers them in a small in-order queue. It then issues them to the BPU one per cycle, so that BPU entry allocation (`wrptr` advance on new-pc updates) and RAS push/pop order always follow program order. It also provides a queue clear for fence.i and predictor invalidation.

---
 rtl/bpu_pkg.sv | 38 +++
 rtl/bp_upd_fifo.sv | 52 +++++
 rtl/bpu_upd_sched.sv | 121 ++++++++++++
 tb/tb_bpu_upd_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch-predictor update scheduler:
// branch-type bit positions, RAS action codes, entry width and packed field offsets.
// Entry packing (MSB..LSB): {new_pc, type, addr, bp_pc, pc, ras_valid, ras_type, ras_pc}.
`ifndef BP_ADDR_BITS
`define BP_ADDR_BITS 32
`endif
`ifndef BP_ADDR_DEPTH
`define BP_ADDR_DEPTH 16
`endif

package bpu_pkg;
  localparam int TYPE_CALL   = 3;
  localparam int TYPE_RET    = 2;
  localparam int TYPE_JAL    = 1;
  localparam int TYPE_BRANCH = 0;

  typedef enum logic [1:0] {
    RAS_NONE     = 2'b00,
    RAS_PUSH     = 2'b01,
    RAS_POP      = 2'b10,
    RAS_POP_PUSH = 2'b11
  } ras_act_e;

  function automatic int entry_w(int ab, int db, int fb, int aw);
    return 1 + fb + aw + ab + db + 1 + 2 + db;
  endfunction

  function automatic int off_ras_pc();                          return 0;                     endfunction
  function automatic int off_ras_type(int db);                  return db;                    endfunction
  function automatic int off_ras_valid(int db);                 return db + 2;                endfunction
  function automatic int off_pc(int db);                        return db + 3;                endfunction
  function automatic int off_bp_pc(int db);                     return 2*db + 3;              endfunction
  function automatic int off_addr(int ab, int db);              return 2*db + 3 + ab;         endfunction
  function automatic int off_type(int ab, int db, int aw);      return 2*db + 3 + ab + aw;    endfunction
  function automatic int off_new_pc(int ab, int db, int aw, int fb);
    return 2*db + 3 + ab + aw + fb;
  endfunction
endpackage

// File: rtl/bp_upd_fifo.sv
// 2-write / 1-read circular FIFO. Port A writes at wrptr, port B at the slot after
// port A (only used together with A). clr zeroes pointers and count synchronously.
module bp_upd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wa_en,
  input  logic [W-1:0]               wa_data,
  input  logic                       wb_en,
  input  logic [W-1:0]               wb_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rdptr, wrptr;

  assign rd_data = mem[rdptr];

  // Storage writes; reset clears contents so the head reads as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (!clr) begin
      if (wa_en) mem[wrptr] <= wa_data;
      if (wb_en) mem[wrptr + PW'(1)] <= wb_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdptr <= '0;
      wrptr <= '0;
      cnt   <= '0;
    end else if (clr) begin
      rdptr <= '0;
      wrptr <= '0;
      cnt   <= '0;
    end else begin
      wrptr <= wrptr + PW'(wa_en) + PW'(wb_en);
      rdptr <= rdptr + PW'(rd_en);
      cnt   <= cnt + CW'(wa_en) + CW'(wb_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/bpu_upd_sched.sv
// Branch-predictor update scheduler: accepts up to two resolved-branch updates per
// cycle (lane 0 older), queues them in order and issues one per cycle to the BPU.
// Optional feature: define BPU_UPD_BYPASS_EN for a zero-latency path when the queue
// is empty (oldest valid lane is presented directly on out_*).
module bpu_upd_sched
  import bpu_pkg::*;
#(
  parameter int N_ADDR_BITS       = `BP_ADDR_BITS,
  parameter int N_DATA_BITS       = 32,
  parameter int N_FLUSH_BYTE_BITS = 4,
  parameter int N_ADDR_W          = $clog2(`BP_ADDR_DEPTH),
  parameter int DEPTH             = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in0_valid,
  output logic                         in0_ready,
  input  logic                         in0_new_pc,
  input  logic [N_FLUSH_BYTE_BITS-1:0] in0_type,
  input  logic [N_ADDR_W-1:0]          in0_addr,
  input  logic [N_ADDR_BITS-1:0]       in0_bp_pc,
  input  logic [N_DATA_BITS-1:0]       in0_pc,
  input  logic                         in0_ras_valid,
  input  logic [1:0]                   in0_ras_type,
  input  logic [N_DATA_BITS-1:0]       in0_ras_pc,
  input  logic                         in1_valid,
  output logic                         in1_ready,
  input  logic                         in1_new_pc,
  input  logic [N_FLUSH_BYTE_BITS-1:0] in1_type,
  input  logic [N_ADDR_W-1:0]          in1_addr,
  input  logic [N_ADDR_BITS-1:0]       in1_bp_pc,
  input  logic [N_DATA_BITS-1:0]       in1_pc,
  input  logic                         in1_ras_valid,
  input  logic [1:0]                   in1_ras_type,
  input  logic [N_DATA_BITS-1:0]       in1_ras_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_new_pc,
  output logic [N_FLUSH_BYTE_BITS-1:0] out_type,
  output logic [N_ADDR_W-1:0]          out_addr,
  output logic [N_ADDR_BITS-1:0]       out_bp_pc,
  output logic [N_DATA_BITS-1:0]       out_pc,
  output logic                         out_ras_valid,
  output logic [1:0]                   out_ras_type,
  output logic [N_DATA_BITS-1:0]       out_ras_pc,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         busy
);
  localparam int EW  = entry_w(N_ADDR_BITS, N_DATA_BITS, N_FLUSH_BYTE_BITS, N_ADDR_W);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int ORP = off_ras_pc();
  localparam int ORT = off_ras_type(N_DATA_BITS);
  localparam int ORV = off_ras_valid(N_DATA_BITS);
  localparam int OPC = off_pc(N_DATA_BITS);
  localparam int OBP = off_bp_pc(N_DATA_BITS);
  localparam int OAD = off_addr(N_ADDR_BITS, N_DATA_BITS);
  localparam int OTY = off_type(N_ADDR_BITS, N_DATA_BITS, N_ADDR_W);
  localparam int ONP = off_new_pc(N_ADDR_BITS, N_DATA_BITS, N_ADDR_W, N_FLUSH_BYTE_BITS);

  logic [EW-1:0] e0, e1, head, od, wa_data;
  logic [CW:0]   free;
  logic          q_nempty, acc0, acc1, byp_show, byp_take, w0, w1, wa_en, wb_en, rd_en;

  assign e0 = {in0_new_pc, in0_type, in0_addr, in0_bp_pc, in0_pc, in0_ras_valid, in0_ras_type, in0_ras_pc};
  assign e1 = {in1_new_pc, in1_type, in1_addr, in1_bp_pc, in1_pc, in1_ras_valid, in1_ras_type, in1_ras_pc};

  // Free slots come from the registered count only; a same-cycle pop never helps.
  assign free      = (CW+1)'(DEPTH) - {1'b0, cnt};
  assign q_nempty  = (cnt != '0);
  assign busy      = q_nempty;
  assign in0_ready = ~rst & ~clr & (free >= (CW+1)'(1));
  assign in1_ready = ~rst & ~clr & (free >= ((CW+1)'(1) + (CW+1)'(in0_valid)));
  assign acc0      = in0_valid & in0_ready;
  assign acc1      = in1_valid & in1_ready;

`ifdef BPU_UPD_BYPASS_EN
  assign byp_show = ~rst & ~clr & ~q_nempty & (in0_valid | in1_valid);
`else
  assign byp_show = 1'b0;
`endif
  // A bypassed lane that the BPU takes this cycle is not written into the queue.
  assign byp_take = byp_show & out_ready;
  assign w0       = acc0 & ~(byp_take & in0_valid);
  assign w1       = acc1 & ~(byp_take & ~in0_valid);
  assign wa_en    = w0 | w1;
  assign wb_en    = w0 & w1;
  assign wa_data  = w0 ? e0 : e1;

  assign out_valid = ~rst & ~clr & (q_nempty | byp_show);
  assign rd_en     = out_valid & out_ready & q_nempty;

  bp_upd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wa_en   (wa_en),
    .wa_data (wa_data),
    .wb_en   (wb_en),
    .wb_data (e1),
    .rd_en   (rd_en),
    .rd_data (head),
    .cnt     (cnt)
  );

  // Output entry select: queue head, bypassed oldest lane, or zero during reset.
  always_comb begin
    od = head;
    if (byp_show) od = in0_valid ? e0 : e1;
    if (rst) od = '0;
  end

  assign out_ras_pc    = od[ORP +: N_DATA_BITS];
  assign out_ras_type  = od[ORT +: 2];
  assign out_ras_valid = od[ORV];
  assign out_pc        = od[OPC +: N_DATA_BITS];
  assign out_bp_pc     = od[OBP +: N_ADDR_BITS];
  assign out_addr      = od[OAD +: N_ADDR_W];
  assign out_type      = od[OTY +: N_FLUSH_BYTE_BITS];
  assign out_new_pc    = od[ONP];
endmodule

// File: tb/tb_bpu_upd_sched.sv
// Self-checking bench for bpu_upd_sched: directed steps plus an in-order scoreboard
// fed on every accepted lane and drained on every issued entry.
module tb_bpu_upd_sched;
  localparam int AB = 32, DB = 32, FB = 4, AW = 4, DEPTH = 4, CW = 3;
  localparam int EW = 1 + FB + AW + AB + DB + 1 + 2 + DB;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, out_ready = 1'b1;
  logic in0_valid, in0_new_pc, in0_ras_valid, in1_valid, in1_new_pc, in1_ras_valid;
  logic [FB-1:0] in0_type, in1_type, out_type;
  logic [AW-1:0] in0_addr, in1_addr, out_addr;
  logic [AB-1:0] in0_bp_pc, in1_bp_pc, out_bp_pc;
  logic [DB-1:0] in0_pc, in1_pc, out_pc, in0_ras_pc, in1_ras_pc, out_ras_pc;
  logic [1:0]    in0_ras_type, in1_ras_type, out_ras_type;
  logic in0_ready, in1_ready, out_valid, out_new_pc, out_ras_valid, busy;
  logic [CW-1:0] cnt;

  int errors = 0, checks = 0;
  logic [EW-1:0] sb[$];
  logic [EW-1:0] p0, p1, po;

  assign p0 = {in0_new_pc, in0_type, in0_addr, in0_bp_pc, in0_pc, in0_ras_valid, in0_ras_type, in0_ras_pc};
  assign p1 = {in1_new_pc, in1_type, in1_addr, in1_bp_pc, in1_pc, in1_ras_valid, in1_ras_type, in1_ras_pc};
  assign po = {out_new_pc, out_type, out_addr, out_bp_pc, out_pc, out_ras_valid, out_ras_type, out_ras_pc};

  bpu_upd_sched #(.N_ADDR_BITS(AB), .N_DATA_BITS(DB), .N_FLUSH_BYTE_BITS(FB),
                  .N_ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_new_pc(in0_new_pc), .in0_type(in0_type),
    .in0_addr(in0_addr), .in0_bp_pc(in0_bp_pc), .in0_pc(in0_pc), .in0_ras_valid(in0_ras_valid),
    .in0_ras_type(in0_ras_type), .in0_ras_pc(in0_ras_pc),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_new_pc(in1_new_pc), .in1_type(in1_type),
    .in1_addr(in1_addr), .in1_bp_pc(in1_bp_pc), .in1_pc(in1_pc), .in1_ras_valid(in1_ras_valid),
    .in1_ras_type(in1_ras_type), .in1_ras_pc(in1_ras_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_new_pc(out_new_pc), .out_type(out_type),
    .out_addr(out_addr), .out_bp_pc(out_bp_pc), .out_pc(out_pc), .out_ras_valid(out_ras_valid),
    .out_ras_type(out_ras_type), .out_ras_pc(out_ras_pc),
    .cnt(cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Lane drivers: side fields are derived from pc so every field varies.
  task automatic drv0(input logic v, input logic [31:0] bpc, input logic [31:0] pc);
    in0_valid = v; in0_bp_pc = bpc; in0_pc = pc; in0_new_pc = pc[0];
    in0_type = 4'b0001 << pc[1:0]; in0_addr = pc[7:4]; in0_ras_valid = pc[2];
    in0_ras_type = pc[9:8]; in0_ras_pc = pc ^ 32'h5a5a_0000;
  endtask

  task automatic drv1(input logic v, input logic [31:0] bpc, input logic [31:0] pc);
    in1_valid = v; in1_bp_pc = bpc; in1_pc = pc; in1_new_pc = pc[0];
    in1_type = 4'b0001 << pc[1:0]; in1_addr = pc[7:4]; in1_ras_valid = pc[2];
    in1_ras_type = pc[9:8]; in1_ras_pc = pc ^ 32'h0000_a5a5;
  endtask

  // Scoreboard: record accepted lanes (lane 0 first), then compare any issued entry.
  always @(negedge clk) begin
    if (rst || clr) begin
      sb.delete();
    end else begin
      if (in0_valid && in0_ready) sb.push_back(p0);
      if (in1_valid && in1_ready) sb.push_back(p1);
      if (out_valid && out_ready) begin
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) chk("sb_entry", po, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int sent, cyc;
    logic acc;
    logic [31:0] r;
    drv0(0, 0, 0); drv1(0, 0, 0);

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_out_bp_pc", out_bp_pc, 0);
    rst = 1'b0; #1;
    chk("rel_in0_ready", in0_ready, 1);
    chk("rel_in1_ready", in1_ready, 1);

    // Dual push ordering
    out_ready = 1'b1;
    drv0(1, 32'h100, 32'h1235); drv1(1, 32'h200, 32'h2346); #1;
    chk("dual_rdy0", in0_ready, 1);
    chk("dual_rdy1", in1_ready, 1);
`ifdef BPU_UPD_BYPASS_EN
    chk("dual_n_bp", out_bp_pc, 32'h100);
    tick(); drv0(0, 0, 0); drv1(0, 0, 0); #1;
    chk("dual_n1_bp", out_bp_pc, 32'h200);
    chk("dual_n1_cnt", cnt, 1);
    tick();
    chk("dual_n2_busy", busy, 0);
`else
    chk("dual_n_valid", out_valid, 0);
    tick(); drv0(0, 0, 0); drv1(0, 0, 0); #1;
    chk("dual_n1_bp", out_bp_pc, 32'h100);
    chk("dual_n1_cnt", cnt, 2);
    tick();
    chk("dual_n2_bp", out_bp_pc, 32'h200);
    chk("dual_n2_cnt", cnt, 1);
    tick();
    chk("dual_n3_busy", busy, 0);
`endif

    // Fill to DEPTH, then nearly-full back-check
    out_ready = 1'b0;
    drv0(1, 32'h110, 32'h1117); drv1(1, 32'h210, 32'h2118);
    tick();
    drv0(1, 32'h120, 32'h1129); drv1(1, 32'h220, 32'h222a);
    tick();
    drv0(0, 0, 0); drv1(0, 0, 0); #1;
    chk("fill_cnt", cnt, 4);
    chk("fill_rdy0", in0_ready, 0);
    chk("fill_rdy1", in1_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_head", out_bp_pc, 32'h110);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("nf_cnt", cnt, 3);
    drv0(1, 32'h130, 32'h113b); drv1(1, 32'h230, 32'h223c); #1;
    chk("nf_rdy0", in0_ready, 1);
    chk("nf_rdy1", in1_ready, 0);
    tick();
    drv0(0, 0, 0); drv1(0, 0, 0);
    chk("nf_cnt_after", cnt, 4);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("fill_drained", busy, 0);

    // Clear with pending entries and a same-cycle valid lane
    out_ready = 1'b0;
    drv0(1, 32'h140, 32'h114d); drv1(1, 32'h240, 32'h224e);
    tick();
    drv1(0, 0, 0); drv0(1, 32'h150, 32'h115f);
    tick();
    drv0(0, 0, 0);
    chk("clr_pre_cnt", cnt, 3);
    clr = 1'b1; drv0(1, 32'hdead, 32'hdead); #1;
    chk("clr_rdy0", in0_ready, 0);
    chk("clr_out_valid", out_valid, 0);
    tick();
    clr = 1'b0; drv0(0, 0, 0); #1;
    chk("clr_cnt", cnt, 0);
    chk("clr_out_valid_next", out_valid, 0);
    out_ready = 1'b1;
    tick();
    chk("clr_never_issued", out_valid, 0);
    chk("clr_busy", busy, 0);

    // Reset mid-stream
    out_ready = 1'b0;
    drv0(1, 32'h160, 32'h1161); drv1(1, 32'h260, 32'h2262);
    tick();
    drv1(0, 0, 0); drv0(1, 32'h170, 32'h1173);
    tick();
    drv0(0, 0, 0);
    chk("mrst_pre_cnt", cnt, 3);
    rst = 1'b1; #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_rdy0", in0_ready, 0);
    tick();
    rst = 1'b0; #1;
    chk("mrst_rel_rdy0", in0_ready, 1);
    chk("mrst_rel_rdy1", in1_ready, 1);

    // Empty-queue latency
    out_ready = 1'b1;
    drv0(1, 32'h180, 32'h300); #1;
`ifdef BPU_UPD_BYPASS_EN
    chk("byp_out_valid", out_valid, 1);
    chk("byp_out_pc", out_pc, 32'h300);
    tick(); drv0(0, 0, 0); #1;
    chk("byp_cnt", cnt, 0);
`else
    chk("nobyp_out_valid", out_valid, 0);
    tick(); drv0(0, 0, 0); #1;
    chk("nobyp_out_valid_n1", out_valid, 1);
    chk("nobyp_out_pc", out_pc, 32'h300);
    chk("nobyp_cnt", cnt, 1);
    tick();
    chk("nobyp_busy", busy, 0);
`endif

    // Wrap: 11 single pushes with random back-pressure
    sent = 0; cyc = 0;
    while (sent < 11 && cyc < 300) begin
      r = $urandom;
      out_ready = r[31];
      drv0(1, 32'h400 + sent, {r[30:12], sent[3:0], r[7:0]}); #1;
      chk("wrap_cnt_le_depth", cnt <= DEPTH, 1);
      acc = in0_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    chk("wrap_all_sent", sent, 11);
    drv0(0, 0, 0);
    out_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("wrap_drained", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
